// File: rtl/polyphase_halfband_interp.sv
// Two-phase half-band interpolator (x2) with one serial multiplier and valid/ready on both ports.
// Optional macro POLYPHASE_INTERP_SAT_EN: saturate the odd-phase sample instead of wrapping it.
module polyphase_halfband_interp #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int K            = 8,
  parameter logic [K*COEF_WIDTH-1:0] COEFFS = {-16'sd59, 16'sd196, -16'sd471, 16'sd958,
                                               -16'sd1815, 16'sd3338, -16'sd6424, 16'sd20661}
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    phase_out
);

  localparam int PRE_W  = SAMPLE_WIDTH + 1;
  localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH + 1;
  localparam int ACC_W  = PROD_W + $clog2(K);
  localparam int TAP_W  = (K > 1) ? $clog2(K) : 1;
  localparam int IDX_W  = $clog2(2 * K);
  localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(2 ** (COEF_WIDTH - 2));

  typedef enum logic [2:0] {IDLE, MAC, ROUND, EMIT0, EMIT1} state_t;

  state_t state, state_nxt;

  logic signed [SAMPLE_WIDTH-1:0] dly [2*K];
  logic signed [ACC_W-1:0]        acc;
  logic [TAP_W-1:0]               tap;
  logic signed [SAMPLE_WIDTH-1:0] y1_q;

  logic [IDX_W-1:0]               lo_idx, hi_idx;
  logic signed [SAMPLE_WIDTH-1:0] tap_lo, tap_hi;
  logic signed [PRE_W-1:0]        pre_sum;
  logic signed [COEF_WIDTH-1:0]   coef;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        rounded, shifted;
  logic signed [SAMPLE_WIDTH-1:0] y1_val;

  // Symmetric pair for tap k: d[K-1-k] and d[K+k], walking outward from the centre.
  assign lo_idx  = IDX_W'(K - 1) - IDX_W'(tap);
  assign hi_idx  = IDX_W'(K) + IDX_W'(tap);
  assign tap_lo  = dly[lo_idx];
  assign tap_hi  = dly[hi_idx];
  assign pre_sum = {tap_lo[SAMPLE_WIDTH-1], tap_lo} + {tap_hi[SAMPLE_WIDTH-1], tap_hi};

  always_comb begin
    coef = '0;
    for (int i = 0; i < K; i++)
      if (tap == TAP_W'(i)) coef = COEFFS[i*COEF_WIDTH +: COEF_WIDTH];
  end

  assign prod    = PROD_W'(pre_sum) * PROD_W'(coef);
  assign rounded = acc + ROUND_C;
  assign shifted = rounded >>> (COEF_WIDTH - 1);

`ifdef POLYPHASE_INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (SAMPLE_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  always_comb begin
    y1_val = SAMPLE_WIDTH'(shifted);
    if (shifted > SAT_MAX)      y1_val = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) y1_val = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  end
`else
  assign y1_val = SAMPLE_WIDTH'(shifted);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_in  = 1'b0;
    valid_out = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) state_nxt = MAC;
      end
      MAC:   if (tap == TAP_W'(K - 1)) state_nxt = ROUND;
      ROUND: state_nxt = EMIT0;
      EMIT0: begin
        valid_out = 1'b1;
        if (ready_out) state_nxt = EMIT1;
      end
      EMIT1: begin
        valid_out = 1'b1;
        if (ready_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2 * K; i++) dly[i] <= '0;
      acc       <= '0;
      tap       <= '0;
      y1_q      <= '0;
      data_out  <= '0;
      phase_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          dly[0] <= data_in;
          for (int i = 1; i < 2 * K; i++) dly[i] <= dly[i-1];
          acc <= '0;
          tap <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          tap <= tap + TAP_W'(1);
        end
        ROUND: begin
          y1_q      <= y1_val;
          data_out  <= dly[K];
          phase_out <= 1'b0;
        end
        EMIT0: if (ready_out) begin
          data_out  <= y1_q;
          phase_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_halfband_interp.sv
// Bench for polyphase_halfband_interp: random and directed samples scored against a direct-form convolution model.
module tb_polyphase_halfband_interp;
  localparam int K = 8;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [15:0] data_out;
  logic        phase_out;

  int errors;
  int checks;
  int cyc;
  int hist[$];
  int coef[K] = '{20661, -6424, 3338, -1815, 958, -471, 196, -59};

  polyphase_halfband_interp dut (
    .clk(clk), .reset_n(reset_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .phase_out(phase_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint xh(int idx);
    if (idx < 0 || idx >= hist.size()) return 0;
    return longint'(hist[idx]);
  endfunction

  // Output pair for input n: y0 = x[n-K]; y1 = rounded symmetric FIR midpoint between x[n-K] and x[n-K+1].
  function automatic int exp_y0(int n);
    return int'(xh(n - K));
  endfunction

  function automatic longint raw_y1(int n);
    longint s = 0;
    for (int k = 0; k < K; k++)
      s += longint'(coef[k]) * (xh(n - K + 1 + k) + xh(n - K - k));
    return (s + 64'sd16384) >>> 15;
  endfunction

  function automatic int exp_y1(int n);
    longint r = raw_y1(n);
`ifdef POLYPHASE_INTERP_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
`else
    longint w = r & 64'd65535;
    if (w >= 32768) w -= 65536;
    return int'(w);
`endif
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic do_reset();
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    hist.delete();
    @(negedge clk);
  endtask

  // Sends one sample with ready_out held high and collects its output pair.
  task automatic drive_one(input int s, output int y0, output int p0, output int y1, output int p1,
                           output int acc_c, output int v0_c, output int v1_c, output bit to);
    int n;
    int got;
    to = 1'b0; y0 = 0; p0 = 0; y1 = 0; p1 = 0; v0_c = 0; v1_c = 0;
    valid_in  = 1'b1;
    data_in   = 16'(s);
    ready_out = 1'b1;
    n = 0;
    while (ready_in !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) to = 1'b1;
    acc_c = cyc;
    hist.push_back(s);
    @(negedge clk);
    valid_in = 1'b0;
    got = 0;
    n = 0;
    while (got < 2 && n < 64) begin
      if (valid_out === 1'b1) begin
        if (got == 0) begin y0 = $signed(data_out); p0 = int'(phase_out); v0_c = cyc; end
        else          begin y1 = $signed(data_out); p1 = int'(phase_out); v1_c = cyc; end
        got++;
      end
      @(negedge clk);
      n++;
    end
    if (got < 2) to = 1'b1;
  endtask

  task automatic test_reset();
    int y0, p0, y1, p1, ac, v0c, v1c;
    bit to;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0 || data_out !== 16'd0 || phase_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready_in=%b valid_out=%b data_out=%h phase_out=%b want 1 0 0000 0",
               ready_in, valid_out, data_out, phase_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive_one(12345, y0, p0, y1, p1, ac, v0c, v1c, to);
    checks++;
    if (to || y1 !== exp_y1(0)) begin
      errors++;
      $display("FAIL reset_pre_sample: timeout=%0d y1=%0d want %0d", to, y1, exp_y1(0));
    end
    valid_in = 1'b1;
    data_in  = 16'(-20000);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0 || data_out !== 16'd0 || phase_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mac: ready_in=%b valid_out=%b data_out=%h phase_out=%b want 1 0 0000 0",
               ready_in, valid_out, data_out, phase_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
    @(negedge clk);
    drive_one(rnd_sample(), y0, p0, y1, p1, ac, v0c, v1c, to);
    checks++;
    if (to || y0 !== 0 || y1 !== exp_y1(0) || p0 !== 0 || p1 !== 1) begin
      errors++;
      $display("FAIL reset_after: timeout=%0d y0=%0d y1=%0d p=%0d%0d want 0 %0d 01",
               to, y0, y1, p0, p1, exp_y1(0));
    end
  endtask

  task automatic test_impulse();
    int imp_odd[16] = '{59, -196, 471, -958, 1815, -3338, 6424, -20661,
                        -20661, 6424, -3338, 1815, -958, 471, -196, 59};
    int y0, p0, y1, p1, ac, v0c, v1c;
    bit to;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      drive_one((n == 0) ? -32768 : 0, y0, p0, y1, p1, ac, v0c, v1c, to);
      checks++;
      if (to || y1 !== imp_odd[n] || y0 !== ((n == 8) ? -32768 : 0) || p0 !== 0 || p1 !== 1) begin
        errors++;
        $display("FAIL impulse[%0d]: timeout=%0d y0=%0d y1=%0d p=%0d%0d want %0d %0d 01",
                 n, to, y0, y1, p0, p1, (n == 8) ? -32768 : 0, imp_odd[n]);
      end
      if (n == 0) begin
        checks++;
        if (v0c - ac !== K + 2 || v1c - v0c !== 1) begin
          errors++;
          $display("FAIL latency: first_valid=%0d spacing=%0d want %0d 1", v0c - ac, v1c - v0c, K + 2);
        end
      end
    end
  endtask

  task automatic test_dc();
    int y0, p0, y1, p1, ac, v0c, v1c;
    bit to;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive_one(10000, y0, p0, y1, p1, ac, v0c, v1c, to);
      checks++;
      if (n >= 15) begin
        if (to || y0 !== 10000 || y1 !== 10000) begin
          errors++;
          $display("FAIL dc_settled[%0d]: y0=%0d y1=%0d want 10000 10000", n, y0, y1);
        end
      end else if (to || y0 !== exp_y0(n) || y1 !== exp_y1(n)) begin
        errors++;
        $display("FAIL dc_ramp[%0d]: y0=%0d y1=%0d want %0d %0d", n, y0, y1, exp_y0(n), exp_y1(n));
      end
    end
  endtask

  task automatic test_saturation();
    int sgn[16] = '{-1, 1, -1, 1, -1, 1, -1, 1, 1, -1, 1, -1, 1, -1, 1, -1};
    int y0, p0, y1, p1, ac, v0c, v1c;
    bit to;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      drive_one(sgn[n] * 32767, y0, p0, y1, p1, ac, v0c, v1c, to);
      checks++;
      if (to || y0 !== exp_y0(n) || y1 !== exp_y1(n)) begin
        errors++;
        $display("FAIL sat_seq[%0d]: y0=%0d y1=%0d want %0d %0d", n, y0, y1, exp_y0(n), exp_y1(n));
      end
    end
    checks++;
`ifdef POLYPHASE_INTERP_SAT_EN
    if (y0 !== 32767 || y1 !== 32767) begin
      errors++;
      $display("FAIL sat_clip: y0=%0d y1=%0d want 32767 32767", y0, y1);
    end
`else
    if (y0 !== 32767 || y1 !== int'(16'(raw_y1(15))) - ((raw_y1(15) & 64'd32768) != 0 ? 65536 : 0)) begin
      errors++;
      $display("FAIL sat_wrap: y0=%0d y1=%0d raw=%0d", y0, y1, raw_y1(15));
    end
`endif
  endtask

  task automatic test_random();
    int y0, p0, y1, p1, ac, v0c, v1c;
    bit to;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      drive_one(rnd_sample(), y0, p0, y1, p1, ac, v0c, v1c, to);
      checks++;
      if (to || y0 !== exp_y0(n) || y1 !== exp_y1(n) || p0 !== 0 || p1 !== 1) begin
        errors++;
        $display("FAIL random[%0d]: y0=%0d y1=%0d p=%0d%0d want %0d %0d 01",
                 n, y0, y1, p0, p1, exp_y0(n), exp_y1(n));
      end
    end
  endtask

  task automatic test_backpressure();
    int s1, s2, n, got, y0, y1;
    do_reset();
    s1 = rnd_sample();
    s2 = rnd_sample();
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 16'(s1);
    hist.push_back(s1);
    @(negedge clk);
    data_in = 16'(s2);
    n = 0;
    while (valid_out !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64 || $signed(data_out) !== exp_y0(0) || phase_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_y0: data_out=%0d phase=%b want %0d 0", $signed(data_out), phase_out, exp_y0(0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ($signed(data_out) !== exp_y0(0) || phase_out !== 1'b0 || ready_in !== 1'b0 || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold0[%0d]: data_out=%0d phase=%b ready_in=%b valid_out=%b want %0d 0 0 1",
                 i, $signed(data_out), phase_out, ready_in, valid_out, exp_y0(0));
      end
    end
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ($signed(data_out) !== exp_y1(0) || phase_out !== 1'b1 || ready_in !== 1'b0 || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold1[%0d]: data_out=%0d phase=%b ready_in=%b valid_out=%b want %0d 1 0 1",
                 i, $signed(data_out), phase_out, ready_in, valid_out, exp_y1(0));
      end
      @(negedge clk);
    end
    ready_out = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid_out=%b ready_in=%b want 0 1", valid_out, ready_in);
    end
    hist.push_back(s2);
    @(negedge clk);
    valid_in = 1'b0;
    got = 0; n = 0; y0 = 0; y1 = 0;
    while (got < 2 && n < 64) begin
      if (valid_out === 1'b1) begin
        if (got == 0) y0 = $signed(data_out);
        else          y1 = $signed(data_out);
        got++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (got < 2 || y0 !== exp_y0(1) || y1 !== exp_y1(1)) begin
      errors++;
      $display("FAIL bp_second: got=%0d y0=%0d y1=%0d want 2 %0d %0d", got, y0, y1, exp_y0(1), exp_y1(1));
    end
  endtask

  task automatic test_back_to_back();
    int y0, p0, y1, p1, ac, v0c, v1c, prev_ac;
    bit to;
    do_reset();
    prev_ac = 0;
    for (int n = 0; n < 6; n++) begin
      drive_one(rnd_sample(), y0, p0, y1, p1, ac, v0c, v1c, to);
      checks++;
      if (to || y0 !== exp_y0(n) || y1 !== exp_y1(n) || p0 !== 0 || p1 !== 1 || v1c - v0c !== 1) begin
        errors++;
        $display("FAIL b2b_data[%0d]: y0=%0d y1=%0d p=%0d%0d gap=%0d want %0d %0d 01 1",
                 n, y0, y1, p0, p1, v1c - v0c, exp_y0(n), exp_y1(n));
      end
      if (n > 0) begin
        checks++;
        if (ac - prev_ac !== K + 4) begin
          errors++;
          $display("FAIL b2b_rate[%0d]: cycles_per_input=%0d want %0d", n, ac - prev_ac, K + 4);
        end
      end
      prev_ac = ac;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    data_in   = '0;
    #12;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
